// File: rtl/inflate_wr_dma_if.sv
// rtl/inflate_wr_dma_if.sv - bus bundle for the inflate write-DMA stage
// Purpose: groups the APB register port, the halfword input stream, the
//   decoder end-of-stream flag, the AHB-Lite write master and the wr_done
//   pulse into one interface.
// Modports:
//   slave  - the DMA's view (APB/stream/HREADY in, PRDATA/AHB/wr_done out)
//   master - the environment's view (the mirror of slave)
// Signals:
//   PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[31:0], PRDATA[31:0]  APB
//   data_in[15:0], data_in_vld, data_in_rdy                          halfword stream
//   src_done                                                         decoder finished
//   HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HWDATA[31:0], HREADY  AHB-Lite
//   wr_done                                                          completion pulse
interface inflate_wr_dma_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic [15:0] data_in;
  logic        data_in_vld;
  logic        data_in_rdy;
  logic        src_done;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        wr_done;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  data_in, data_in_vld, src_done, HREADY,
    output PRDATA, data_in_rdy, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, wr_done
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output data_in, data_in_vld, src_done, HREADY,
    input  PRDATA, data_in_rdy, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, wr_done
  );
endinterface

// File: rtl/inflate_wr_dma.sv
// rtl/inflate_wr_dma.sv - write-DMA packing inflate halfwords into AHB-Lite writes
// Purpose: accepts 16-bit halfwords (low byte first) from the inflate output
//   FIFO, packs two per 32-bit word and writes each word to memory as a single
//   AHB-Lite NONSEQ write. A trailing odd halfword is written with HSIZE=half.
//   Configured and monitored over APB; pulses wr_done when the decoder's
//   end-of-stream has been written out.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    inflate_wr_dma_if.slave (APB, halfword stream, src_done, AHB-Lite, wr_done)
// Registers (PADDR[4:2]): 0 WRADDR, 1 CTRL, 2 STATUS, 3 WCNT, 4 LIMIT
// Optional feature: define INFLATE_WR_DMA_LIMIT_EN to enable the LIMIT register
//   and the overflow stop; otherwise LIMIT reads 0 and ovfl never sets.
module inflate_wr_dma #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  inflate_wr_dma_if.slave bus
);

  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HSIZE_HALF = 3'b001;

  localparam logic [2:0] REG_WRADDR = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_WCNT   = 3'd3;
  localparam logic [2:0] REG_LIMIT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      wraddr_q, wraddr_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             ovfl_q, ovfl_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]      buf_q, buf_d;
  logic             half_q, half_d;     // lower lane holds a pending halfword
  logic [2:0]       size_q, size_d;
  logic             sds_q, sds_d;       // src_done seen during this job
  logic [31:0]      prdata_q, prdata_d;
  logic [31:0]      rdata;
  logic [CNT_W:0]   wsum;
  logic             apb_wr;
  logic [2:0]       reg_sel;
  logic [31:0]      limit_rd;
  logic             unused_paddr;

`ifdef INFLATE_WR_DMA_LIMIT_EN
  logic [CNT_W-1:0] limit_q, limit_d;
  assign limit_rd = 32'(limit_q);
`else
  assign limit_rd = 32'd0;
`endif

  assign apb_wr       = bus.PSEL & bus.PENABLE & bus.PWRITE;
  assign reg_sel      = bus.PADDR[4:2];
  assign unused_paddr = ^{bus.PADDR[31:5], bus.PADDR[1:0]};

  // One extra bit catches the carry so WCNT can saturate instead of wrapping.
  always_comb begin
    wsum = {1'b0, wcnt_q} + ((size_q == HSIZE_WORD) ? (CNT_W+1)'(4) : (CNT_W+1)'(2));
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_WRADDR: rdata = wraddr_q;
      REG_CTRL:   rdata = {31'd0, start_q};
      REG_STATUS: rdata = {29'd0, ovfl_q, done_q, (state_q != S_IDLE)};
      REG_WCNT:   rdata = 32'(wcnt_q);
      REG_LIMIT:  rdata = limit_rd;
      default:    rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wraddr_d = wraddr_q;
    start_d  = start_q;
    done_d   = done_q;
    ovfl_d   = ovfl_q;
    wcnt_d   = wcnt_q;
    buf_d    = buf_q;
    half_d   = half_q;
    size_d   = size_q;
    sds_d    = sds_q;
    prdata_d = prdata_q;
`ifdef INFLATE_WR_DMA_LIMIT_EN
    limit_d  = limit_q;
`endif

    // Read data is captured in the setup phase so PRDATA is stable in the access phase.
    if (bus.PSEL && !bus.PENABLE) begin
      prdata_d = rdata;
    end

    if (apb_wr) begin
      case (reg_sel)
        REG_WRADDR: wraddr_d = {bus.PWDATA[31:2], 2'b00};
        REG_CTRL:   start_d  = bus.PWDATA[0];
        REG_STATUS: begin
          if (bus.PWDATA[1]) done_d = 1'b0;
          if (bus.PWDATA[2]) ovfl_d = 1'b0;
        end
`ifdef INFLATE_WR_DMA_LIMIT_EN
        REG_LIMIT:  limit_d = bus.PWDATA[CNT_W-1:0];
`endif
        default: ;
      endcase
    end

    if (bus.src_done && state_q != S_IDLE) begin
      sds_d = 1'b1;
    end

    // Hardware updates below take priority over a coincident APB write.
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_FILL;
          wcnt_d  = '0;
          buf_d   = 32'd0;
          half_d  = 1'b0;
          size_d  = HSIZE_WORD;
          sds_d   = 1'b0;
        end
      end
      S_FILL: begin
        if (!start_q) begin
          state_d = S_IDLE;
          half_d  = 1'b0;
        end else if (bus.data_in_vld) begin
          if (half_q) begin
            buf_d[31:16] = bus.data_in;
            half_d       = 1'b0;
            size_d       = HSIZE_WORD;
            state_d      = S_ADDR;
          end else begin
            buf_d  = {16'd0, bus.data_in};
            half_d = 1'b1;
          end
        end else if (sds_q) begin
          if (half_q) begin
            half_d  = 1'b0;
            size_d  = HSIZE_HALF;
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR: begin
        if (!start_q) begin
          state_d = S_IDLE;
        end else if (bus.HREADY) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // An abort here still lets the write in flight complete.
        if (bus.HREADY) begin
          wraddr_d = wraddr_q + 32'd4;
          wcnt_d   = wsum[CNT_W] ? '1 : wsum[CNT_W-1:0];
          size_d   = HSIZE_WORD;
          if (!start_q) begin
            state_d = S_IDLE;
          end else begin
`ifdef INFLATE_WR_DMA_LIMIT_EN
            if (limit_q != '0 && wcnt_d >= limit_q) begin
              ovfl_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_FILL;
            end
`else
            state_d = S_FILL;
`endif
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        start_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wraddr_q <= 32'd0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      ovfl_q   <= 1'b0;
      wcnt_q   <= '0;
      buf_q    <= 32'd0;
      half_q   <= 1'b0;
      size_q   <= HSIZE_WORD;
      sds_q    <= 1'b0;
      prdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      wraddr_q <= wraddr_d;
      start_q  <= start_d;
      done_q   <= done_d;
      ovfl_q   <= ovfl_d;
      wcnt_q   <= wcnt_d;
      buf_q    <= buf_d;
      half_q   <= half_d;
      size_q   <= size_d;
      sds_q    <= sds_d;
      prdata_q <= prdata_d;
    end
  end

`ifdef INFLATE_WR_DMA_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_q <= '0;
    end else begin
      limit_q <= limit_d;
    end
  end
`endif

  // HADDR/HWDATA come straight from WRADDR and the pack buffer, so they are
  // stable for the whole address and data phase and zero while in reset.
  assign bus.HADDR       = wraddr_q;
  assign bus.HWDATA      = buf_q;
  assign bus.HSIZE       = size_q;
  assign bus.HTRANS      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign bus.HWRITE      = (state_q == S_ADDR);
  assign bus.data_in_rdy = (state_q == S_FILL) && start_q;
  assign bus.wr_done     = (state_q == S_DONE);
  assign bus.PRDATA      = prdata_q;

endmodule
